// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush generator for the 5-stage core. Hazard sources from ID,
// EX and the LSU are combined into per-pipeline-register stall and flush
// strobes. Wait states for multi-cycle MDU operations and outstanding loads
// are tracked in a small FSM. A watchdog flags a wait that lasts too long and
// a saturating counter records how many cycles the PC was held.
//
// Parameters:
//   REDIRECT_BUBBLES  total cycles ifid_flush is held per redirect (>= 1)
//   TIMEOUT           wait cycles before hang_err is raised
//   CNT_W             width of stall_cnt
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   id_rs1_ren/addr, id_rs2_ren/addr   ID-stage source register reads
//   ex_rd_ena/addr, ex_load_flag   EX-stage destination and load marker
//   ex_redirect                    EX resolved taken branch/jump/trap
//   ex_mdu_start, mdu_done         multi-cycle MDU occupancy / completion
//   mem_req_valid/ready            LSU load request handshake
//   mem_resp_valid                 load data returned
//   pc_stall .. memwb_flush        combinational stall/flush strobes
//   hang_err                       sticky watchdog error (registered)
//   stall_cnt                      saturating count of pc_stall cycles
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REDIRECT_BUBBLES = 2,
    parameter int TIMEOUT          = 1024,
    parameter int CNT_W            = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_rs1_ren,
    input  logic [4:0]       id_rs1_addr,
    input  logic             id_rs2_ren,
    input  logic [4:0]       id_rs2_addr,
    input  logic             ex_rd_ena,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_load_flag,
    input  logic             ex_redirect,
    input  logic             ex_mdu_start,
    input  logic             mdu_done,
    input  logic             mem_req_valid,
    input  logic             mem_req_ready,
    input  logic             mem_resp_valid,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             hang_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int RC_W = (REDIRECT_BUBBLES > 1) ? $clog2(REDIRECT_BUBBLES) : 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(REDIRECT_BUBBLES - 1);
    localparam logic [RC_W-1:0]  RC_ONE  = RC_W'(1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MDU_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [RC_W-1:0]   rd_cnt_reg, rd_cnt_next;
    logic [WD_W-1:0]   wd_reg, wd_next;
    logic              hang_err_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;

    logic mem_hs;
    logic mem_hold;
    logic mdu_hold;
    logic redirect_act;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;

    assign mem_hs   = mem_req_valid & mem_req_ready;
    // A wait state stops holding the pipeline in the cycle its completion
    // pulse arrives, so the pipeline advances in that same cycle.
    assign mem_hold = (state_reg == MEM_WAIT) & ~mem_resp_valid;
    // The MDU stall starts in the ex_mdu_start cycle itself, before the FSM
    // has moved to MDU_WAIT.
    assign mdu_hold = ((state_reg == MDU_WAIT) | ((state_reg == IDLE) & ex_mdu_start))
                      & ~mdu_done;
    assign redirect_act = ex_redirect | (rd_cnt_reg != '0);

    assign rs1_hit  = id_rs1_ren & (id_rs1_addr == ex_rd_addr);
    assign rs2_hit  = id_rs2_ren & (id_rs2_addr == ex_rd_addr);
    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_load_flag & ex_rd_ena & (ex_rd_addr != 5'd0) & (rs1_hit | rs2_hit);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                // A response in the handshake cycle means there is nothing to wait for.
                if (mem_hs && !mem_resp_valid) begin
                    state_next = MEM_WAIT;
                end else if (ex_mdu_start && !mdu_done) begin
                    state_next = MDU_WAIT;
                end
            end
            MDU_WAIT: begin
                if (mdu_done) begin
                    state_next = IDLE;
                end
            end
            MEM_WAIT: begin
                if (mem_resp_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Strict priority: only the highest active condition drives any strobe,
    // which also guarantees no register sees stall and flush together.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (!rst) begin
            if (mem_hold) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
                memwb_flush = 1'b1;
            end else if (mdu_hold) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_flush = 1'b1;
            end else if (redirect_act) begin
                ifid_flush  = 1'b1;
                idex_flush  = ex_redirect;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_flush  = 1'b1;
            end
        end
    end

    // ----------------------------------------------- redirect bubble counter
    // Frozen while a wait holds EX, since the redirecting instruction and the
    // fetch stream behind it are not moving.
    always_comb begin
        rd_cnt_next = rd_cnt_reg;
        if (!(mem_hold || mdu_hold)) begin
            if (ex_redirect) begin
                rd_cnt_next = RC_LOAD;
            end else if (rd_cnt_reg != '0) begin
                rd_cnt_next = rd_cnt_reg - RC_ONE;
            end
        end
    end

    // -------------------------------------------------------------- watchdog
    // Counts cycles spent in a wait state; saturates at TIMEOUT so the flag
    // comparison stays valid for arbitrarily long hangs.
    always_comb begin
        wd_next = wd_reg;
        if (state_next == IDLE) begin
            wd_next = '0;
        end else if ((state_reg != IDLE) && (wd_reg != WD_MAX)) begin
            wd_next = wd_reg + WD_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_reg    <= '0;
            wd_reg        <= '0;
            hang_err_reg  <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            rd_cnt_reg   <= rd_cnt_next;
            wd_reg       <= wd_next;
            hang_err_reg <= hang_err_reg | (wd_next == WD_MAX);
            if (pc_stall && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
            end
        end
    end

    assign hang_err  = hang_err_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed scenarios with hand-derived expected strobes, followed by a
// randomized run checked against a cycle-level behavioural model of the
// hazard rules. Inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int RB  = 2;
    localparam int TO  = 8;
    localparam int CW  = 5;
    localparam int CNT_SAT = (1 << CW) - 1;

    // Strobe vector order: {pc_stall, ifid_stall, ifid_flush, idex_stall,
    //                       idex_flush, exmem_stall, exmem_flush, memwb_flush}
    localparam logic [7:0] S_NONE = 8'b0000_0000;
    localparam logic [7:0] S_LU   = 8'b1100_1000;
    localparam logic [7:0] S_RD0  = 8'b0010_1000;
    localparam logic [7:0] S_RD1  = 8'b0010_0000;
    localparam logic [7:0] S_MDU  = 8'b1101_0010;
    localparam logic [7:0] S_MEM  = 8'b1101_0101;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_rs1_ren, id_rs2_ren;
    logic [4:0]    id_rs1_addr, id_rs2_addr;
    logic          ex_rd_ena, ex_load_flag, ex_redirect, ex_mdu_start, mdu_done;
    logic [4:0]    ex_rd_addr;
    logic          mem_req_valid, mem_req_ready, mem_resp_valid;
    logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic          exmem_stall, exmem_flush, memwb_flush, hang_err;
    logic [CW-1:0] stall_cnt;
    logic [7:0]    strobes;

    int checks = 0;
    int errors = 0;

    assign strobes = {pc_stall, ifid_stall, ifid_flush, idex_stall,
                      idex_flush, exmem_stall, exmem_flush, memwb_flush};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REDIRECT_BUBBLES (RB),
        .TIMEOUT          (TO),
        .CNT_W            (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1_ren     (id_rs1_ren),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_ren     (id_rs2_ren),
        .id_rs2_addr    (id_rs2_addr),
        .ex_rd_ena      (ex_rd_ena),
        .ex_rd_addr     (ex_rd_addr),
        .ex_load_flag   (ex_load_flag),
        .ex_redirect    (ex_redirect),
        .ex_mdu_start   (ex_mdu_start),
        .mdu_done       (mdu_done),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .pc_stall       (pc_stall),
        .ifid_stall     (ifid_stall),
        .ifid_flush     (ifid_flush),
        .idex_stall     (idex_stall),
        .idex_flush     (idex_flush),
        .exmem_stall    (exmem_stall),
        .exmem_flush    (exmem_flush),
        .memwb_flush    (memwb_flush),
        .hang_err       (hang_err),
        .stall_cnt      (stall_cnt)
    );

    task automatic idle_inputs();
        id_rs1_ren     = 1'b0;
        id_rs1_addr    = 5'd0;
        id_rs2_ren     = 1'b0;
        id_rs2_addr    = 5'd0;
        ex_rd_ena      = 1'b0;
        ex_rd_addr     = 5'd0;
        ex_load_flag   = 1'b0;
        ex_redirect    = 1'b0;
        ex_mdu_start   = 1'b0;
        mdu_done       = 1'b0;
        mem_req_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic on_rs1, input logic [4:0] src);
        ex_load_flag = 1'b1;
        ex_rd_ena    = 1'b1;
        ex_rd_addr   = rd;
        if (on_rs1) begin
            id_rs1_ren  = 1'b1;
            id_rs1_addr = src;
        end else begin
            id_rs2_ren  = 1'b1;
            id_rs2_addr = src;
        end
    endtask

    // ------------------------------------------------------------------ reset
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        set_load_use(5'd5, 1'b0, 5'd5);
        ex_redirect = 1'b1;
        @(negedge clk);
        checks++;
        if (strobes !== S_NONE) begin
            errors++;
            $display("FAIL reset_gate: strobes=%b expected=%b", strobes, S_NONE);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (hang_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_hang: hang_err=%b expected=0", hang_err);
        end
        checks++;
        if (stall_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt: stall_cnt=%0d expected=0", stall_cnt);
        end
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (strobes !== S_NONE) begin
            errors++;
            $display("FAIL reset_idle: strobes=%b expected=%b", strobes, S_NONE);
        end
        next_cycle();
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    // --------------------------------------------------------------- load-use
    task automatic test_load_use();
        logic [7:0] exp_tab [6];
        exp_tab = '{S_LU, S_NONE, S_NONE, S_LU, S_NONE, S_NONE};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            case (i)
                0: set_load_use(5'd5, 1'b0, 5'd5);       // rs2 match
                1: begin id_rs2_ren = 1'b1; id_rs2_addr = 5'd5; end // no load in EX
                2: set_load_use(5'd0, 1'b0, 5'd0);       // x0 target
                3: set_load_use(5'd7, 1'b1, 5'd7);       // rs1 match
                4: begin set_load_use(5'd7, 1'b1, 5'd7); id_rs1_ren = 1'b0; end
                default: begin set_load_use(5'd9, 1'b0, 5'd9); ex_rd_ena = 1'b0; end
            endcase
            @(negedge clk);
            checks++;
            if (strobes !== exp_tab[i]) begin
                errors++;
                $display("FAIL load_use_%0d: strobes=%b expected=%b", i, strobes, exp_tab[i]);
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (stall_cnt !== CW'(2)) begin
            errors++;
            $display("FAIL load_use_cnt: stall_cnt=%0d expected=2", stall_cnt);
        end
        next_cycle();
        $display("test_load_use done: checks=%0d errors=%0d", checks, errors);
    endtask

    // --------------------------------------------------------------- redirect
    task automatic test_redirect();
        logic [7:0] exp_tab [7];
        logic       red_tab [7];
        exp_tab = '{S_RD0, S_RD1, S_NONE, S_RD0, S_RD0, S_RD1, S_NONE};
        red_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            idle_inputs();
            ex_redirect = red_tab[i];
            if (i == 0) set_load_use(5'd3, 1'b0, 5'd3);  // masked by the redirect
            @(negedge clk);
            checks++;
            if (strobes !== exp_tab[i]) begin
                errors++;
                $display("FAIL redirect_%0d: strobes=%b expected=%b", i, strobes, exp_tab[i]);
            end
            next_cycle();
        end
        $display("test_redirect done: checks=%0d errors=%0d", checks, errors);
    endtask

    // -------------------------------------------------------------------- MDU
    task automatic test_mdu();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            ex_mdu_start = (i == 0);
            mdu_done     = (i == 4);
            @(negedge clk);
            checks++;
            if (strobes !== ((i < 4) ? S_MDU : S_NONE)) begin
                errors++;
                $display("FAIL mdu_%0d: strobes=%b expected=%b", i, strobes,
                         (i < 4) ? S_MDU : S_NONE);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (stall_cnt !== CW'(4)) begin
            errors++;
            $display("FAIL mdu_cnt: stall_cnt=%0d expected=4", stall_cnt);
        end
        // Same-cycle completion never enters a wait.
        ex_mdu_start = 1'b1;
        mdu_done     = 1'b1;
        @(negedge clk);
        checks++;
        if (strobes !== S_NONE) begin
            errors++;
            $display("FAIL mdu_fast: strobes=%b expected=%b", strobes, S_NONE);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (strobes !== S_NONE) begin
            errors++;
            $display("FAIL mdu_fast_after: strobes=%b expected=%b", strobes, S_NONE);
        end
        next_cycle();
        // MDU outranks a redirect; the redirect is not latched meanwhile.
        ex_mdu_start = 1'b1;
        ex_redirect  = 1'b1;
        @(negedge clk);
        checks++;
        if (strobes !== S_MDU) begin
            errors++;
            $display("FAIL mdu_vs_redirect: strobes=%b expected=%b", strobes, S_MDU);
        end
        next_cycle();
        idle_inputs();
        mdu_done = 1'b1;
        @(negedge clk);
        checks++;
        if (strobes !== S_NONE) begin
            errors++;
            $display("FAIL mdu_vs_redirect_exit: strobes=%b expected=%b", strobes, S_NONE);
        end
        next_cycle();
        idle_inputs();
        $display("test_mdu done: checks=%0d errors=%0d", checks, errors);
    endtask

    // ----------------------------------------------------------------- memory
    task automatic test_mem();
        logic [7:0] exp_tab [5];
        exp_tab = '{S_RD0, S_MEM, S_MEM, S_RD1, S_NONE};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            mem_req_valid  = (i == 0);
            mem_req_ready  = (i == 0);
            ex_redirect    = (i <= 1);   // second pulse lands inside the wait
            mem_resp_valid = (i == 3);
            @(negedge clk);
            checks++;
            if (strobes !== exp_tab[i]) begin
                errors++;
                $display("FAIL mem_%0d: strobes=%b expected=%b", i, strobes, exp_tab[i]);
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (stall_cnt !== CW'(2)) begin
            errors++;
            $display("FAIL mem_cnt: stall_cnt=%0d expected=2", stall_cnt);
        end
        // Zero-latency response, then a request without ready.
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            mem_req_valid  = (i != 2);
            mem_req_ready  = (i == 0);
            mem_resp_valid = (i == 0);
            @(negedge clk);
            checks++;
            if (strobes !== S_NONE) begin
                errors++;
                $display("FAIL mem_nowait_%0d: strobes=%b expected=%b", i, strobes, S_NONE);
            end
            next_cycle();
        end
        idle_inputs();
        $display("test_mem done: checks=%0d errors=%0d", checks, errors);
    endtask

    // --------------------------------------------------------------- watchdog
    task automatic test_watchdog();
        logic exp_h;
        do_reset();
        mem_req_valid = 1'b1;
        mem_req_ready = 1'b1;
        next_cycle();
        idle_inputs();
        for (int k = 1; k <= 40; k++) begin
            exp_h = (k >= TO + 1);
            @(negedge clk);
            checks++;
            if (hang_err !== exp_h || strobes !== S_MEM) begin
                errors++;
                $display("FAIL watchdog_%0d: hang_err=%b strobes=%b expected hang_err=%b strobes=%b",
                         k, hang_err, strobes, exp_h, S_MEM);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (stall_cnt !== CW'(CNT_SAT)) begin
            errors++;
            $display("FAIL stall_cnt_sat: stall_cnt=%0d expected=%0d", stall_cnt, CNT_SAT);
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (hang_err !== 1'b0 || strobes !== S_NONE || stall_cnt !== '0) begin
            errors++;
            $display("FAIL watchdog_reset: hang_err=%b strobes=%b stall_cnt=%0d expected 0/%b/0",
                     hang_err, strobes, stall_cnt, S_NONE);
        end
        next_cycle();
        $display("test_watchdog done: checks=%0d errors=%0d", checks, errors);
    endtask

    // ------------------------------------------------------- reset mid-wait
    task automatic test_reset_mid_mdu();
        do_reset();
        ex_mdu_start = 1'b1;
        next_cycle();
        idle_inputs();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (strobes !== S_NONE) begin
            errors++;
            $display("FAIL rst_mid_mdu: strobes=%b expected=%b", strobes, S_NONE);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (strobes !== S_NONE || stall_cnt !== '0) begin
            errors++;
            $display("FAIL rst_mid_mdu_after: strobes=%b stall_cnt=%0d expected %b/0",
                     strobes, stall_cnt, S_NONE);
        end
        next_cycle();
        $display("test_reset_mid_mdu done: checks=%0d errors=%0d", checks, errors);
    endtask

    // ----------------------------------------------------------------- random
    // Model: busy flags for the two wait kinds, remaining extra flush cycles,
    // cycles spent waiting, sticky hang flag and a saturating stall tally.
    task automatic test_random();
        bit         m_mem, m_mdu, m_hang, was_busy, mem_hold, mdu_hold, lu;
        int         m_bub, m_age, m_stalls, nerr;
        logic [7:0] exp_s;
        do_reset();
        m_mem = 0; m_mdu = 0; m_hang = 0; m_bub = 0; m_age = 0; m_stalls = 0;
        nerr = errors;
        for (int n = 0; n < 800; n++) begin
            rst            = ($urandom_range(0, 99) == 0);
            id_rs1_ren     = 1'($urandom_range(0, 1));
            id_rs1_addr    = 5'($urandom_range(0, 3));
            id_rs2_ren     = 1'($urandom_range(0, 1));
            id_rs2_addr    = 5'($urandom_range(0, 3));
            ex_rd_ena      = ($urandom_range(0, 3) != 0);
            ex_rd_addr     = 5'($urandom_range(0, 3));
            ex_load_flag   = ($urandom_range(0, 2) == 0);
            ex_redirect    = ($urandom_range(0, 9) == 0);
            ex_mdu_start   = ($urandom_range(0, 11) == 0);
            mdu_done       = ($urandom_range(0, 6) == 0);
            mem_req_valid  = !ex_mdu_start && ($urandom_range(0, 5) == 0);
            mem_req_ready  = 1'($urandom_range(0, 1));
            mem_resp_valid = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            exp_s = S_NONE;
            mem_hold = m_mem && !mem_resp_valid;
            mdu_hold = !m_mem && (m_mdu || ex_mdu_start) && !mdu_done;
            lu = ex_load_flag && ex_rd_ena && ex_rd_addr != 0 &&
                 ((id_rs1_ren && id_rs1_addr == ex_rd_addr) ||
                  (id_rs2_ren && id_rs2_addr == ex_rd_addr));
            if (!rst) begin
                if (mem_hold)                      exp_s = S_MEM;
                else if (mdu_hold)                 exp_s = S_MDU;
                else if (ex_redirect)              exp_s = S_RD0;
                else if (m_bub > 0)                exp_s = S_RD1;
                else if (lu)                       exp_s = S_LU;
            end
            checks++;
            if (strobes !== exp_s || hang_err !== m_hang || stall_cnt !== m_stalls[CW-1:0]) begin
                errors++;
                $display("FAIL random_%0d: strobes=%b hang=%b cnt=%0d expected %b/%b/%0d",
                         n, strobes, hang_err, stall_cnt, exp_s, m_hang, m_stalls);
            end
            if (rst) begin
                m_mem = 0; m_mdu = 0; m_hang = 0; m_bub = 0; m_age = 0; m_stalls = 0;
            end else begin
                was_busy = m_mem || m_mdu;
                if (m_mem) begin
                    if (mem_resp_valid) m_mem = 0;
                end else if (m_mdu) begin
                    if (mdu_done) m_mdu = 0;
                end else if (mem_req_valid && mem_req_ready && !mem_resp_valid) begin
                    m_mem = 1;
                end else if (ex_mdu_start && !mdu_done) begin
                    m_mdu = 1;
                end
                if (!(mem_hold || mdu_hold)) begin
                    if (ex_redirect)     m_bub = RB - 1;
                    else if (m_bub > 0)  m_bub--;
                end
                if (!(m_mem || m_mdu)) m_age = 0;
                else if (was_busy)     m_age++;
                if (m_age >= TO) m_hang = 1;
                if (exp_s[7] && m_stalls < CNT_SAT) m_stalls++;
            end
            next_cycle();
        end
        rst = 1'b0;
        idle_inputs();
        $display("test_random done: 800 cycles, new errors=%0d", errors - nerr);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_use();
        test_redirect();
        test_mdu();
        test_mem();
        test_watchdog();
        test_reset_mid_mdu();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
